// File: rtl/temp_mon_pkg.sv
// Shared definitions for the temperature monitor: default geometry, alert window
// and the sequencer state encoding.
package temp_mon_pkg;

  localparam int TEMP_WIDTH = 8;
  localparam int S_NR       = 8;
  localparam int T_MIN      = 19;
  localparam int T_MAX      = 26;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    DIVIDE = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/seq_division.sv
// Restoring divider producing one quotient bit per clock, MSB first.
// The load cycle already performs the first step, so valid rises WIDTH cycles after load.
module seq_division #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             load,
  input  logic [WIDTH-1:0] N,
  input  logic [WIDTH-1:0] D,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] den;
  logic [CW-1:0]    step_cnt;
  logic [WIDTH-1:0] src_rem, src_quo, src_den;
  logic [WIDTH-1:0] step_rem, step_quo;
  logic [WIDTH:0]   shifted;

  // Q doubles as the dividend shift register; R is the partial remainder.
  always_comb begin
    src_rem  = load ? '0 : R;
    src_quo  = load ? N  : Q;
    src_den  = load ? D  : den;
    shifted  = {src_rem, src_quo[WIDTH-1]};
    step_rem = shifted[WIDTH-1:0];
    step_quo = {src_quo[WIDTH-2:0], 1'b0};
    if (shifted >= {1'b0, src_den}) begin
      step_rem = WIDTH'(shifted - {1'b0, src_den});
      step_quo = {src_quo[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      den      <= '0;
      step_cnt <= '0;
      busy     <= 1'b0;
      valid    <= 1'b0;
      Q        <= '0;
      R        <= '0;
    end else if (load) begin
      den      <= D;
      Q        <= step_quo;
      R        <= step_rem;
      step_cnt <= CW'(1);
      busy     <= 1'b1;
      valid    <= 1'b0;
    end else if (busy) begin
      Q        <= step_quo;
      R        <= step_rem;
      step_cnt <= step_cnt + CW'(1);
      if (step_cnt == CW'(WIDTH - 1)) begin
        busy  <= 1'b0;
        valid <= 1'b1;
      end
    end else begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/temp_avg_sequencer.sv
// Multi-cycle temperature monitor: samples the sensors on start, accumulates the enabled
// readings one per cycle, divides sum by count and decodes the average into LEDs and alert.
module temp_avg_sequencer
  import temp_mon_pkg::*;
#(
  parameter int TEMP_WIDTH_P = TEMP_WIDTH,
  parameter int S_NR_P       = S_NR,
  parameter int T_MIN_P      = T_MIN,
  parameter int T_MAX_P      = T_MAX
) (
  input  logic                             clk_i,
  input  logic                             rst_n_i,
  input  logic                             start_i,
  input  logic [S_NR_P*TEMP_WIDTH_P-1:0]   sensors_data_i,
  input  logic [S_NR_P-1:0]                sensors_en_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic [2*TEMP_WIDTH_P-1:0]        avg_o,
  output logic [2*TEMP_WIDTH_P-1:0]        rem_o,
  output logic [T_MAX_P-T_MIN_P:0]         led_output_o,
  output logic                             alert_o
);

  localparam int W2    = 2 * TEMP_WIDTH_P;
  localparam int LED_W = T_MAX_P - T_MIN_P + 1;
  localparam int IDX_W = (S_NR_P > 1) ? $clog2(S_NR_P) : 1;

  state_t                          state;
  logic [S_NR_P*TEMP_WIDTH_P-1:0]  data_reg;
  logic [S_NR_P-1:0]               en_reg;
  logic [IDX_W-1:0]                idx;
  logic [W2-1:0]                   sum, count;

  logic [TEMP_WIDTH_P-1:0]         cur_data;
  logic [W2-1:0]                   sum_next, count_next;
  logic                            last_idx, div_load;
  logic                            div_busy, div_valid;
  logic [W2-1:0]                   div_q, div_r;
  logic                            in_range;
  logic [LED_W-1:0]                led_next;

  // The last sensor's contribution feeds the divider on the same edge it is accumulated.
  assign cur_data   = data_reg[int'(idx)*TEMP_WIDTH_P +: TEMP_WIDTH_P];
  assign sum_next   = sum + (en_reg[idx] ? W2'(cur_data) : '0);
  assign count_next = count + W2'(en_reg[idx]);
  assign last_idx   = (idx == IDX_W'(S_NR_P - 1));
  assign div_load   = (state == ACCUM) && last_idx && (count_next != '0);

  seq_division #(
    .WIDTH (W2)
  ) u_div (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .load    (div_load),
    .N       (sum_next),
    .D       (count_next),
    .busy    (div_busy),
    .valid   (div_valid),
    .Q       (div_q),
    .R       (div_r)
  );

  assign in_range = (div_q >= W2'(T_MIN_P)) && (div_q <= W2'(T_MAX_P));

  generate
    for (genvar gi = 0; gi < LED_W; gi++) begin : g_led
      assign led_next[gi] = in_range && (div_q == W2'(T_MIN_P + gi));
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= IDLE;
      data_reg     <= '0;
      en_reg       <= '0;
      idx          <= '0;
      sum          <= '0;
      count        <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      avg_o        <= '0;
      rem_o        <= '0;
      led_output_o <= '0;
      alert_o      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_o <= 1'b0;
          if (start_i) begin
            data_reg <= sensors_data_i;
            en_reg   <= sensors_en_i;
            idx      <= '0;
            sum      <= '0;
            count    <= '0;
            busy_o   <= 1'b1;
            state    <= ACCUM;
          end
        end
        ACCUM: begin
          sum   <= sum_next;
          count <= count_next;
          idx   <= idx + IDX_W'(1);
          if (last_idx) begin
            if (count_next == '0) begin
              avg_o        <= '0;
              rem_o        <= '0;
              led_output_o <= '0;
              alert_o      <= 1'b1;
              done_o       <= 1'b1;
              state        <= DONE;
            end else begin
              state <= DIVIDE;
            end
          end
        end
        DIVIDE: begin
          if (div_valid && !div_busy) begin
            avg_o        <= div_q;
            rem_o        <= div_r;
            led_output_o <= led_next;
            alert_o      <= !in_range;
            done_o       <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          done_o <= 1'b0;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_temp_avg_sequencer.sv
// Directed bench for temp_avg_sequencer: hand-computed averages, LED/alert boundaries,
// latency, busy window, ignored starts and mid-run reset.
module tb_temp_avg_sequencer;
  import temp_mon_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [63:0] sensors_data;
  logic [7:0]  sensors_en;
  logic        busy, done, alert;
  logic [15:0] avg, rem;
  logic [7:0]  led;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] prev_avg;

  always #5 clk = ~clk;

  temp_avg_sequencer dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .start_i        (start),
    .sensors_data_i (sensors_data),
    .sensors_en_i   (sensors_en),
    .busy_o         (busy),
    .done_o         (done),
    .avg_o          (avg),
    .rem_o          (rem),
    .led_output_o   (led),
    .alert_o        (alert)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"},  32'(busy),  0);
    chk({tag, "_done"},  32'(done),  0);
    chk({tag, "_avg"},   32'(avg),   0);
    chk({tag, "_rem"},   32'(rem),   0);
    chk({tag, "_led"},   32'(led),   0);
    chk({tag, "_alert"}, 32'(alert), 0);
  endtask

  // Pulses start for edge 0 and scrambles the live inputs afterwards; returns in cycle 1.
  task automatic start_run(input logic [7:0] en, input logic [63:0] data);
    @(negedge clk);
    sensors_en   = en;
    sensors_data = data;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start        = 1'b0;
    sensors_en   = ~en;
    sensors_data = ~data;
  endtask

  task automatic run(input string name, input logic [7:0] en, input logic [63:0] data,
                     input int exp_avg, input int exp_rem, input int exp_led,
                     input int exp_alert, input int exp_cycle, input int pa, input int pb);
    int done_cycle, done_cnt, busy_bad;
    done_cycle = -1;
    done_cnt   = 0;
    busy_bad   = 0;
    start_run(en, data);
    chk({name, "_hold"}, 32'(avg), 32'(prev_avg));
    for (int c = 1; c <= 40; c++) begin
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cycle < 0) done_cycle = c;
      end
      if (c <= exp_cycle && busy !== 1'b1) busy_bad++;
      if (c > exp_cycle && busy !== 1'b0) busy_bad++;
      start = (c == pa) || (c == pb);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    chk({name, "_latency"},  32'(done_cycle), 32'(exp_cycle));
    chk({name, "_donecnt"},  32'(done_cnt),   1);
    chk({name, "_busy"},     32'(busy_bad),   0);
    chk({name, "_avg"},      32'(avg),        32'(exp_avg));
    chk({name, "_rem"},      32'(rem),        32'(exp_rem));
    chk({name, "_led"},      32'(led),        32'(exp_led));
    chk({name, "_alert"},    32'(alert),      32'(exp_alert));
    $display("run %s: done@%0d avg=%0d rem=%0d led=%02h alert=%0b",
             name, done_cycle, avg, rem, led, alert);
    prev_avg = 16'(exp_avg);
  endtask

  localparam logic [63:0] DATA_C1 = 64'h0000_0000_1716_1514;  // 20,21,22,23

  initial begin
    int done_seen;
    rst_n        = 1'b0;
    start        = 1'b0;
    sensors_en   = '0;
    sensors_data = '0;
    prev_avg     = '0;
    #1;
    chk_outputs_zero("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run("c1_avg21",   8'h0F, DATA_C1,               21, 2, 8'h04, 0, 25, 0, 0);
    run("c2_none",    8'h00, DATA_C1,                0, 0, 8'h00, 1,  9, 0, 0);
    run("c3_hot30",   8'h01, 64'h0000_0000_0000_001E, 30, 0, 8'h00, 1, 25, 0, 0);
    run("c3_min19",   8'h01, 64'h0000_0000_0000_0013, 19, 0, 8'h01, 0, 25, 0, 0);
    run("c3_max26",   8'h01, 64'h0000_0000_0000_001A, 26, 0, 8'h80, 0, 25, 0, 0);
    run("c4_allff",   8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 255, 0, 8'h00, 1, 25, 0, 0);
    run("cold18",     8'h03, 64'h0000_0000_0000_1312, 18, 1, 8'h00, 1, 25, 0, 0);
    run("c5_ignore",  8'h0F, DATA_C1,               21, 2, 8'h04, 0, 25, 5, 20);

    // Reset while dividing: outputs clear asynchronously and the run never completes.
    start_run(8'h0F, DATA_C1);
    repeat (14) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("c6_abort");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) done_seen++;
    end
    chk("c6_no_done", 32'(done_seen), 0);
    $display("run c6_abort: done pulses after reset=%0d avg=%0d", done_seen, avg);
    prev_avg = '0;
    run("c6_after",   8'h0F, DATA_C1,               21, 2, 8'h04, 0, 25, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
